// File: rtl/ck_pkg.sv
// ck_pkg: shared definitions for the ck sequence generator and checker.
//   ck_state_e : checker FSM states (HUNT, VERIFY, LOCKED)
//   CK_STEP    : default sequence increment
//   bitrev8    : reverse the bit order of a byte
package ck_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } ck_state_e;

    localparam int unsigned CK_STEP = 7;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ck_rx_if.sv
// ck_rx_if: sample stream into the ck_rx checker and its status outputs.
//   in_valid, in_data            : received (bit-reversed) byte stream
//   locked, match, err_pulse,
//   err_count, expected          : checker status
// master = stream source / status observer, slave = checker.
interface ck_rx_if #(
    parameter int unsigned ERR_W = 16
) ();

    logic             in_valid;
    logic [7:0]       in_data;
    logic             locked;
    logic             match;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       expected;

    modport master (
        output in_valid, in_data,
        input  locked, match, err_pulse, err_count, expected
    );

    modport slave (
        input  in_valid, in_data,
        output locked, match, err_pulse, err_count, expected
    );

endinterface

// File: rtl/ck_rx.sv
// ck_rx: receive-side checker for the bit-reversed arithmetic sequence.
// Acquires the sequence from any starting point, flywheels the prediction
// once locked and counts mismatches seen while locked.
//   clk  : clock, rising edge
//   init : asynchronous active-high reset
//   rx   : ck_rx_if slave (in_valid/in_data in; locked, match, err_pulse,
//          err_count, expected out; all outputs registered)
// ERR_W must match the ERR_W of the connected interface.
module ck_rx
    import ck_pkg::*;
#(
    parameter int unsigned STEP       = CK_STEP,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input logic    clk,
    input logic    init,
    ck_rx_if.slave rx
);

    localparam int unsigned      RUN_W    = $clog2(LOCK_CNT + 1);
    localparam int unsigned      BAD_W    = $clog2(UNLOCK_CNT + 1);
    localparam logic [7:0]       STEP8    = 8'(STEP);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0] BAD_DROP = BAD_W'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    ck_state_e        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
    logic [7:0]       exp_q, exp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             locked_q, locked_d;
    logic             match_q, match_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       v;
    logic             hit;

    assign v       = bitrev8(rx.in_data);
    assign hit     = (v == exp_q);
    assign run_inc = run_q + RUN_W'(1);
    assign bad_inc = bad_q + BAD_W'(1);

    // State and registered outputs
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q  <= HUNT;
            run_q    <= '0;
            bad_q    <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            match_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            bad_q    <= bad_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            match_q  <= match_d;
            pulse_q  <= pulse_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (rx.in_valid) begin
            unique case (state_q)
                HUNT:    state_d = VERIFY;
                VERIFY:  if (hit && run_inc == RUN_LOCK) state_d = LOCKED;
                LOCKED:  if (!hit && bad_inc == BAD_DROP) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Counters, prediction and output strobes
    always_comb begin
        run_d    = run_q;
        bad_d    = bad_q;
        exp_d    = exp_q;
        err_d    = err_q;
        match_d  = 1'b0;
        pulse_d  = 1'b0;
        locked_d = (state_d == LOCKED);
        if (rx.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    exp_d = v + STEP8;
                    run_d = '0;
                    bad_d = '0;
                end
                VERIFY: begin
                    if (hit) begin
                        run_d   = run_inc;
                        exp_d   = exp_q + STEP8;
                        match_d = 1'b1;
                        bad_d   = '0;
                    end else begin
                        // Reseed from the sample; not an error outside LOCKED
                        exp_d = v + STEP8;
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance the prediction regardless of the sample
                    exp_d = exp_q + STEP8;
                    if (hit) begin
                        bad_d   = '0;
                        match_d = 1'b1;
                    end else begin
                        pulse_d = 1'b1;
                        bad_d   = bad_inc;
                        if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                        if (bad_inc == BAD_DROP) begin
                            exp_d = '0;
                            bad_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx.locked    = locked_q;
    assign rx.match     = match_q;
    assign rx.err_pulse = pulse_q;
    assign rx.err_count = err_q;
    assign rx.expected  = exp_q;

endmodule
